// File: rtl/unpack_pkg.sv
// unpack_pkg: shared constants and state encoding for the unpack ingress arbiter
package unpack_pkg;
   localparam int DEF_DATA_WIDTH = 33;
   localparam int EOP_BIT = DEF_DATA_WIDTH - 1;
   typedef enum logic {ST_IDLE = 1'b0, ST_XFER = 1'b1} state_e;
   function automatic int eopBit(input int dataWidth);
      return dataWidth - 1;
   endfunction
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin picker, first requester above last wins, wrapping
module rr_pick #(
   parameter int NUM_PORTS = 4,
   parameter int PORT_W = $clog2(NUM_PORTS)
) (
   input  logic [NUM_PORTS-1:0] req,
   input  logic [PORT_W-1:0]    last,
   output logic [NUM_PORTS-1:0] grant,
   output logic [PORT_W-1:0]    idx,
   output logic                 any
);
   logic [NUM_PORTS-1:0] lowMask, upper;
   logic [2*NUM_PORTS-1:0] dbl;
   always_comb begin
      lowMask = (NUM_PORTS'(2) << last) - NUM_PORTS'(1);
      upper = req & ~lowMask;
      // upper half is the wrap-around copy, so the lowest set bit is the winner
      dbl = {req, upper};
      idx = '0;
      for (int i = 2*NUM_PORTS-1; i >= 0; i--)
         if (dbl[i]) idx = PORT_W'(i % NUM_PORTS);
      any = |req;
      grant = any ? NUM_PORTS'(1) << idx : '0;
   end
endmodule

// File: rtl/unpack_fifo_arbiter.sv
// unpack_fifo_arbiter: packet-granular round-robin drain of ingress FIFOs into one
// registered output stage, with a watchdog that truncates runaway packets.
module unpack_fifo_arbiter
   import unpack_pkg::*;
#(
   parameter int NUM_PORTS = 4,
   parameter int DATA_WIDTH = 33,
   parameter int MAX_PKT_WORDS = 512,
   parameter int PORT_W = $clog2(NUM_PORTS),
   parameter int CNT_W = $clog2(MAX_PKT_WORDS+1)
) (
   input  logic                            iClk,
   input  logic                            iRst,
   input  logic [NUM_PORTS*DATA_WIDTH-1:0] iFifoData,
   input  logic [NUM_PORTS-1:0]            iFifoEmpty,
   output logic [NUM_PORTS-1:0]            oFifoREn,
   output logic [DATA_WIDTH-1:0]           oData,
   output logic                            oVld,
   input  logic                            iRdy,
   output logic [NUM_PORTS-1:0]            oGrant,
   output logic                            oBusy,
   output logic                            oErrTrunc
);
   localparam int EOP = eopBit(DATA_WIDTH);
   state_e state;
   logic [PORT_W-1:0] gIdx, last, pickIdx;
   logic [NUM_PORTS-1:0] req, pickGrant;
   logic [CNT_W-1:0] cnt;
   logic [DATA_WIDTH-1:0] word;
   logic pickAny, pop, isEop, trunc;
   assign req = ~iFifoEmpty;
   assign word = iFifoData[int'(gIdx)*DATA_WIDTH +: DATA_WIDTH];
   assign pop = state == ST_XFER && !iFifoEmpty[gIdx] && (!oVld || iRdy);
   assign isEop = word[EOP];
   assign trunc = !isEop && cnt == CNT_W'(MAX_PKT_WORDS-1);
   assign oFifoREn = pop ? oGrant : '0;
   assign oBusy = state == ST_XFER;
   rr_pick #(.NUM_PORTS(NUM_PORTS), .PORT_W(PORT_W)) uPick (
      .req(req),
      .last(last),
      .grant(pickGrant),
      .idx(pickIdx),
      .any(pickAny)
   );
   always_ff @(posedge iClk or posedge iRst)
      if (iRst) begin
         state <= ST_IDLE;
         gIdx <= '0;
         last <= PORT_W'(NUM_PORTS-1);
         cnt <= '0;
         oGrant <= '0;
         oData <= '0;
         oVld <= 1'b0;
         oErrTrunc <= 1'b0;
      end else begin
         oErrTrunc <= pop && trunc;
         if (pop) begin
            oData <= {isEop | trunc, word[EOP-1:0]};
            oVld <= 1'b1;
         end else if (iRdy)
            oVld <= 1'b0;
         if (state == ST_IDLE) begin
            if (pickAny) begin
               state <= ST_XFER;
               oGrant <= pickGrant;
               gIdx <= pickIdx;
            end
         end else if (pop) begin
            if (isEop || trunc) begin
               state <= ST_IDLE;
               oGrant <= '0;
               last <= gIdx;
               cnt <= '0;
            end else
               cnt <= cnt + 1'b1;
         end
      end
endmodule

// File: tb/tb_unpack_fifo_arbiter.sv
// tb_unpack_fifo_arbiter: directed vectors and corner sequences against a FIFO model
module tb_unpack_fifo_arbiter;
   localparam int NP = 4, DW = 33, MAXW = 4;
   logic clk = 1'b0, rst, rdy = 1'b1;
   logic [NP*DW-1:0] fifoData;
   logic [NP-1:0] fifoEmpty, fifoREn, grant, prevG = '0;
   logic [DW-1:0] dout;
   logic vld, busy, errTrunc;
   logic [DW-1:0] mem [NP][64];
   logic [7:0] rd [NP] = '{default: 8'd0};
   logic [7:0] wr [NP] = '{default: 8'd0};
   logic [DW-1:0] outLog [512];
   int grantLog [64], grantCyc [64];
   int tests = 0, fails = 0;
   int cyc = 0, outCnt = 0, grantCnt = 0, truncCnt = 0, busyCnt = 0, protoErr = 0;

   typedef struct {
      int port;
      int nWords;
      logic [6:0] rdyPat;
      int expTrunc;
      int expGrants;
      int expBusy;
   } vec_t;
   vec_t vecs [5];

   always #5 clk = ~clk;

   unpack_fifo_arbiter #(.NUM_PORTS(NP), .DATA_WIDTH(DW), .MAX_PKT_WORDS(MAXW)) dut (
      .iClk(clk),
      .iRst(rst),
      .iFifoData(fifoData),
      .iFifoEmpty(fifoEmpty),
      .oFifoREn(fifoREn),
      .oData(dout),
      .oVld(vld),
      .iRdy(rdy),
      .oGrant(grant),
      .oBusy(busy),
      .oErrTrunc(errTrunc)
   );

   always_comb begin
      fifoEmpty = '0;
      fifoData = '0;
      for (int k = 0; k < NP; k++) begin
         fifoEmpty[k] = rd[k] == wr[k];
         fifoData[k*DW +: DW] = mem[k][rd[k][5:0]];
      end
   end

   always @(posedge clk)
      for (int k = 0; k < NP; k++)
         if (fifoREn[k]) rd[k] <= rd[k] + 8'd1;

   function automatic int idxOf(input logic [NP-1:0] g);
      for (int k = 0; k < NP; k++)
         if (g[k]) return k;
      return -1;
   endfunction

   always @(negedge clk) begin
      cyc <= cyc + 1;
      prevG <= grant;
      if (!rst) begin
         if ($countones(fifoREn) > 1 || (fifoREn & fifoEmpty) != 0 || (fifoREn & ~grant) != 0 ||
             (fifoREn != 0 && vld && !rdy))
            protoErr <= protoErr + 1;
         if (vld && rdy) begin
            outLog[outCnt] <= dout;
            outCnt <= outCnt + 1;
         end
         if (grant != 0 && prevG == 0) begin
            grantLog[grantCnt] <= idxOf(grant);
            grantCyc[grantCnt] <= cyc;
            grantCnt <= grantCnt + 1;
         end
         if (errTrunc) truncCnt <= truncCnt + 1;
         if (busy) busyCnt <= busyCnt + 1;
      end
   end

   task automatic check(input string name, input longint act, input longint exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic push(input int p, input logic [DW-1:0] w);
      mem[p][wr[p][5:0]] = w;
      wr[p] = wr[p] + 8'd1;
   endtask

   task automatic waitOut(input int target, input int bound, input string name);
      int c;
      c = 0;
      while (outCnt < target && c < bound) begin
         tick;
         c++;
      end
      if (outCnt < target) begin
         tests++;
         fails++;
         $display("FAIL %s timeout: got %0d words expected %0d", name, outCnt, target);
      end
   endtask

   task automatic waitGrant(input logic [NP-1:0] g, input int bound, input string name);
      int c;
      c = 0;
      while (grant != g && c < bound) begin
         tick;
         c++;
      end
      check(name, grant, g);
   endtask

   task automatic runVec(input vec_t v, input int r);
      int o0, g0, t0, b0, c;
      logic e;
      o0 = outCnt;
      g0 = grantCnt;
      t0 = truncCnt;
      b0 = busyCnt;
      c = 0;
      for (int i = 0; i < v.nWords; i++) begin
         e = i == v.nWords - 1;
         push(v.port, {e, 32'(32'hA000 + r*256 + i)});
      end
      while (outCnt - o0 < v.nWords && c < 100) begin
         rdy = v.rdyPat[c % 7];
         tick;
         c++;
      end
      rdy = 1'b1;
      repeat (3) tick;
      check($sformatf("vec%0d words", r), outCnt - o0, v.nWords);
      for (int i = 0; i < v.nWords; i++) begin
         e = i == v.nWords - 1 || i == MAXW - 1;
         check($sformatf("vec%0d word%0d", r, i), outLog[o0+i], {e, 32'(32'hA000 + r*256 + i)});
      end
      check($sformatf("vec%0d trunc", r), truncCnt - t0, v.expTrunc);
      check($sformatf("vec%0d grants", r), grantCnt - g0, v.expGrants);
      check($sformatf("vec%0d grant port", r), grantLog[g0], v.port);
      check($sformatf("vec%0d busy cycles", r), busyCnt - b0, v.expBusy);
   endtask

   initial begin
      int o0, g0, c;
      logic e;
      vecs[0] = '{port: 2, nWords: 3, rdyPat: 7'b1111111, expTrunc: 0, expGrants: 1, expBusy: 3};
      vecs[1] = '{port: 1, nWords: 4, rdyPat: 7'b1011001, expTrunc: 0, expGrants: 1, expBusy: 6};
      vecs[2] = '{port: 3, nWords: 6, rdyPat: 7'b1111111, expTrunc: 1, expGrants: 2, expBusy: 6};
      vecs[3] = '{port: 0, nWords: 2, rdyPat: 7'b0101010, expTrunc: 0, expGrants: 1, expBusy: 3};
      vecs[4] = '{port: 3, nWords: 1, rdyPat: 7'b1111111, expTrunc: 0, expGrants: 1, expBusy: 1};
      rst = 1'b1;
      repeat (2) tick;
      check("reset outputs", {dout, vld, grant, busy, errTrunc, fifoREn}, 0);
      rst = 1'b0;
      tick;
      for (int r = 0; r < 5; r++) runVec(vecs[r], r);

      // fairness: every port holds two 2-word packets
      o0 = outCnt;
      g0 = grantCnt;
      for (int k = 0; k < NP; k++)
         for (int i = 0; i < 4; i++) begin
            e = i % 2 == 1;
            push(k, {e, 32'(32'hB000 + k*256 + i)});
         end
      waitOut(o0 + 16, 200, "fair drain");
      repeat (3) tick;
      for (int i = 0; i < 8; i++) check($sformatf("fair grant%0d", i), grantLog[g0+i], i % 4);
      for (int i = 0; i < 7; i++) check($sformatf("fair gap%0d", i), grantCyc[g0+i+1] - grantCyc[g0+i], 3);
      for (int i = 0; i < 16; i++) begin
         e = i % 2 == 1;
         check($sformatf("fair word%0d", i), outLog[o0+i], {e, 32'(32'hB000 + ((i/2)%4)*256 + (i/8)*2 + i%2)});
      end

      // starvation: granted port goes empty mid-packet while port 0 waits
      o0 = outCnt;
      g0 = grantCnt;
      push(1, {1'b0, 32'hC100});
      push(1, {1'b0, 32'hC101});
      waitGrant(4'b0010, 10, "starve first grant");
      push(0, {1'b1, 32'hC000});
      repeat (7) tick;
      check("starve grant held", grant, 4'b0010);
      check("starve busy held", busy, 1);
      push(1, {1'b1, 32'hC102});
      waitOut(o0 + 4, 50, "starve drain");
      repeat (3) tick;
      check("starve grants", grantCnt - g0, 2);
      check("starve order0", grantLog[g0], 1);
      check("starve order1", grantLog[g0+1], 0);
      check("starve word0", outLog[o0], {1'b0, 32'hC100});
      check("starve word1", outLog[o0+1], {1'b0, 32'hC101});
      check("starve word2", outLog[o0+2], {1'b1, 32'hC102});
      check("starve word3", outLog[o0+3], {1'b1, 32'hC000});

      // reset while port 2 is reading word 2 of 5
      for (int i = 0; i < 5; i++) begin
         e = i == 4;
         push(2, {e, 32'(32'hD000 + i)});
      end
      push(0, {1'b1, 32'hD0FF});
      waitGrant(4'b0100, 10, "rst grant");
      tick;
      check("rst word2 read", fifoREn, 4'b0100);
      rst = 1'b1;
      #1;
      check("rst immediate", {vld, grant, busy, errTrunc, fifoREn}, 0);
      repeat (2) tick;
      rst = 1'b0;
      o0 = outCnt;
      g0 = grantCnt;
      c = 0;
      while (grantCnt == g0 && c < 10) begin
         tick;
         c++;
      end
      check("rst next grant", grantLog[g0], 0);
      c = 0;
      while ((fifoEmpty != 4'hf || busy || vld) && c < 60) begin
         tick;
         c++;
      end
      check("rst drained", outCnt - o0, 5);
      check("rst out0", outLog[o0], {1'b1, 32'hD0FF});
      for (int i = 1; i < 5; i++) begin
         e = i == 4;
         check($sformatf("rst out%0d", i), outLog[o0+i], {e, 32'(32'hD000 + i)});
      end
      check("protocol errors", protoErr, 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end
endmodule
